fetch_pc: RTL
=============

# fetch_pc

Program-counter and instruction-fetch stage of the RV32I single-cycle core. It holds the architectural PC, issues one request per instruction to a variable-latency instruction memory and presents the returned instruction to decode. When the current instruction is consumed, it selects the next PC: PC+4, or the branch/jump target when the branch comparator's `PCSrc` is high.

## Interface
- `N`, 32: PC / address width.
- `RESET_PC`, 32'h0000_0000: PC value after reset. Must be 4-byte aligned.
- `clk` in 1: clock, rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `PCSrc` in 1: take target, from the branch comparator (already combines `Branch` and `Jump`).
- `JumpReg` in 1: the current instruction is JALR; clear bit 0 of `Target`.
- `Target` in N: computed target, PC+imm or rs1+imm.
- `stall` in 1: downstream hold; the instruction is not consumed this cycle.
- `imem_req` out 1: fetch request.
- `imem_addr` out N: fetch address, equal to `pc`.
- `imem_gnt` in 1: request accepted.
- `imem_rvalid` in 1: read data valid.
- `imem_rdata` in 32: instruction word.
- `instr` out 32: registered instruction to decode.
- `instr_valid` out 1: `instr` is valid for the current `pc`.
- `pc` out N: PC of `instr`.
- `pc_plus4` out N: `pc` + 4, used for the JAL/JALR link value.
- `misaligned` out 1: sticky instruction-address-misaligned flag.

## Operation
- FSM states: FETCH, WAIT, HOLD, HALT.
- **FETCH**
  - `imem_req`=1, `imem_addr`=`pc`.
  - On `imem_gnt`, go to WAIT; otherwise stay in FETCH with `req` and `addr` unchanged.
- **WAIT**
  - `imem_req`=0.
  - On `imem_rvalid`: `instr` <= `imem_rdata`, `instr_valid` <= 1, go to HOLD.
- **HOLD**
  - `instr_valid`=1. The instruction is consumed in any HOLD cycle with `stall`=0.
  - Next-target computation: `tgt` = `JumpReg` ? {`Target`[N-1:1],1'b0} : `Target`.
  - `next_pc` = `PCSrc` ? `tgt` : `pc`+4.
  - On consume with `PCSrc`=1 and `tgt`[1:0]≠0:
    - `pc` is unchanged; `misaligned` <= 1.
    - `instr_valid` <= 0; go to HALT.
  - On any other consume: `pc` <= `next_pc`, `instr_valid` <= 0, go to FETCH.
  - While `stall`=1: `instr`, `pc` and `instr_valid` hold.
- **HALT**
  - Terminal state; `imem_req`=0, `instr_valid`=0.
  - Exits only through reset.
- `PCSrc`, `JumpReg` and `Target` are sampled only in consume cycles and ignored otherwise.
- Width rules:
  - `pc`+4 is modulo 2^N, so 0xFFFF_FFFC+4 = 0x0000_0000.
  - `pc_plus4` is combinational from `pc`.
- `imem_rvalid` outside WAIT is ignored, as is `imem_gnt` outside FETCH.

## Timing
- Reset values:
  - `pc`=`RESET_PC`; `instr`=32'h0000_0013 (NOP).
  - `instr_valid`=0, `imem_req`=0, `misaligned`=0; state=FETCH.
- `imem_req` is a registered-state decode, so it is low during reset. It rises in the first cycle after `rst_n` deasserts.
- Memory contract:
  - `imem_gnt` may arrive in the same cycle `imem_req` rises.
  - `imem_rvalid` comes no earlier than the cycle after `gnt`.
  - There is one outstanding request at most.
- Minimum cadence with `gnt` in cycle 0 and `rvalid` in cycle 1:
  - `instr_valid` is high in cycle 2.
  - If consumed in cycle 2, the new `pc` and `imem_req` appear in cycle 3.
  - Result: 3 cycles per instruction.
- Reset mid-operation: any state returns to FETCH with reset values. An `rvalid` belonging to the aborted transaction, arriving while in FETCH, is ignored.
- In HOLD with `stall` high, `PCSrc` may toggle freely with no effect until the consume cycle.

## Test plan
- **Reset and sequential fetch.** Release reset with `RESET_PC`=0, `gnt` immediate, `rvalid` one cycle later, `stall`=0, `PCSrc`=0.
  - `imem_addr` sequence is 0x0, 0x4, 0x8.
  - `instr_valid` pulses every 3rd cycle, and `pc_plus4` = `pc`+4.
- **Taken branch.** In HOLD at `pc`=0x10, drive `PCSrc`=1, `Target`=0x40.
  - Next `imem_addr`=0x40 and `pc`=0x40.
  - With `PCSrc`=0 instead, next `pc`=0x14.
- **JALR LSB clear and misalignment.**
  - `JumpReg`=1, `Target`=0x101, `PCSrc`=1: `pc` becomes 0x100.
  - `Target`=0x102: `misaligned`=1, `pc` stays at its old value, `imem_req` stays 0 thereafter, and only `rst_n` clears the flag.
- **Stall and delayed grant.**
  - Hold `imem_gnt`=0 for 5 cycles: `imem_req` and `imem_addr` stay stable.
  - Then `stall`=1 for 4 cycles in HOLD, with `PCSrc` toggling: `instr` and `pc` are stable, and `pc` advances by exactly +4 after `stall` drops.
- **Wrap and spurious/aborted responses.**
  - From `pc`=0xFFFF_FFFC, consume with `PCSrc`=0: next `pc`=0x0.
  - Pulse `imem_rvalid` in FETCH: no effect.
  - Assert `rst_n`=0 in WAIT, release it, then send a late `rvalid`: `instr_valid` stays 0 and `imem_addr`=`RESET_PC`.

Source files
------------

// File: rtl/fetch_pc.sv
// Program counter and instruction-fetch stage: one imem request per instruction,
// holds the returned word for decode and steps to PC+4 or the branch/jump target.
module fetch_pc #(
  parameter int unsigned    N        = 32,
  parameter logic [N-1:0]   RESET_PC = {N{1'b0}}
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          PCSrc,
  input  logic          JumpReg,
  input  logic [N-1:0]  Target,
  input  logic          stall,
  output logic          imem_req,
  output logic [N-1:0]  imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [31:0]   imem_rdata,
  output logic [31:0]   instr,
  output logic          instr_valid,
  output logic [N-1:0]  pc,
  output logic [N-1:0]  pc_plus4,
  output logic          misaligned,
  output logic [1:0]    fsm_state
);

  // Handshake: a fetch is issued while imem_req is high and completes on the
  // cycle imem_gnt is seen with it; exactly one imem_rvalid follows, no earlier
  // than the next cycle. Decode consumes instr in any cycle with instr_valid=1
  // and stall=0.

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [N-1:0] PC_STEP     = N'(4);
  localparam logic [N-1:0] RESET_PC_AL = {RESET_PC[N-1:2], 2'b00};
  localparam logic [31:0]  NOP_WORD    = 32'h0000_0013;

  state_t         state_q, state_d;
  logic           req_q;
  logic [N-1:0]   pc_q;
  logic [31:0]    instr_q;
  logic           valid_q;
  logic           misaligned_q;

  logic           consume;
  logic           take_bad;
  logic [N-1:0]   tgt;
  logic [N-1:0]   seq_pc;
  logic [N-1:0]   next_pc;

  // State register. imem_req is decoded from the next state so it is a clean
  // flop output that stays low throughout reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= (state_d == S_FETCH);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: if (req_q && imem_gnt) state_d = S_WAIT;
      S_WAIT:  if (imem_rvalid)       state_d = S_HOLD;
      S_HOLD:  if (consume)           state_d = take_bad ? S_HALT : S_FETCH;
      S_HALT:                         state_d = S_HALT;
      default:                        state_d = S_FETCH;
    endcase
  end

  // Output and next-PC decode
  always_comb begin
    consume     = (state_q == S_HOLD) && !stall;
    tgt         = JumpReg ? {Target[N-1:1], 1'b0} : Target;
    seq_pc      = pc_q + PC_STEP;
    next_pc     = PCSrc ? tgt : seq_pc;
    take_bad    = PCSrc && (tgt[1:0] != 2'b00);
    imem_req    = req_q;
    imem_addr   = pc_q;
    instr       = instr_q;
    instr_valid = valid_q;
    pc          = pc_q;
    pc_plus4    = seq_pc;
    misaligned  = misaligned_q;
    fsm_state   = state_q;
  end

  // Datapath: a misaligned taken target freezes the PC and parks the stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC_AL;
      instr_q      <= NOP_WORD;
      valid_q      <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      if ((state_q == S_WAIT) && imem_rvalid) begin
        instr_q <= imem_rdata;
        valid_q <= 1'b1;
      end
      if (consume) begin
        valid_q <= 1'b0;
        if (take_bad) begin
          misaligned_q <= 1'b1;
        end else begin
          pc_q <= next_pc;
        end
      end
    end
  end

endmodule
